min_dist_engine: RTL and testbench

- Hardware responder for the minimum-pair-distance task. Sits beside data memory `dm1` in `top`.
- On a start pulse it reads N signed 8-bit samples from data memory into an internal buffer. It then walks every unordered pair (i>j), tracks the minimum absolute difference, and writes that byte to RESULT_ADDR.
- It signals completion on `done`, which is the same start/done protocol the program benches drive and poll.

---
 rtl/min_dist_pkg.sv | 18 +
 rtl/min_dist_engine_abs_diff9.sv | 18 +
 rtl/min_dist_engine.sv | 148 ++++++++++++++
 tb/tb_min_dist_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/min_dist_pkg.sv
// Shared types and constants for the minimum-pair-distance engine.
package min_dist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LOAD_DRAIN,
        PAIR,
        WRITE,
        DONE
    } state_t;

    typedef logic [7:0]        dist_t;
    typedef logic signed [7:0] sample_t;

    localparam dist_t DIST_INIT = 8'hFF;

endpackage

// File: rtl/min_dist_engine_abs_diff9.sv
// Absolute difference of two signed bytes, computed in 9 bits so the
// full -128..127 span cannot overflow; the magnitude always fits in 8 bits.
module abs_diff9
    import min_dist_pkg::*;
(
    input  sample_t i_a,
    input  sample_t i_b,
    output dist_t   o_dist
);

    logic signed [8:0] w_diff;

    always_comb begin
        w_diff = {i_a[7], i_a} - {i_b[7], i_b};
        o_dist = w_diff[8] ? 8'(-w_diff) : w_diff[7:0];
    end

endmodule

// File: rtl/min_dist_engine.sv
// Loads N samples from data memory, scans every unordered pair for the
// smallest absolute difference and writes that byte back to RESULT_ADDR.
module min_dist_engine
    import min_dist_pkg::*;
#(
    parameter int N           = 20,
    parameter int BASE        = 128,
    parameter int RESULT_ADDR = 127,
    parameter int AW          = 8,
    parameter int DW          = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          mem_wr_en,
    output logic [DW-1:0] mem_wr_data,
    output logic          busy,
    output logic          done,
    output logic [7:0]    min_dist
);

    localparam int IW = $clog2(N);

    if (N < 2 || N > 64) begin : g_bad_n
        $error("min_dist_engine: N must be in 2..64");
    end
    if (BASE + N - 1 > (1 << AW) - 1) begin : g_bad_base
        $error("min_dist_engine: sample window exceeds address space");
    end
    if (RESULT_ADDR >= BASE && RESULT_ADDR <= BASE + N - 1) begin : g_bad_result
        $error("min_dist_engine: RESULT_ADDR overlaps the sample window");
    end
    if (DW < 8) begin : g_bad_dw
        $error("min_dist_engine: DW must be at least 8");
    end

    state_t  r_state;
    state_t  w_nextState;
    logic [IW-1:0] r_k;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_j;
    dist_t   r_min;
    sample_t r_buf [N];
    dist_t   w_dist;
    logic    w_lastPair;

    abs_diff9 u_abs_diff9 (
        .i_a    (r_buf[r_i]),
        .i_b    (r_buf[r_j]),
        .o_dist (w_dist)
    );

    assign w_lastPair = (r_i == IW'(N - 1)) && (r_j == IW'(N - 2));
    assign min_dist   = r_min;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_nextState = LOAD;
            end
            LOAD: begin
                busy     = 1'b1;
                mem_addr = AW'(BASE) + AW'(r_k);
                if (r_k == IW'(N - 1)) w_nextState = LOAD_DRAIN;
            end
            LOAD_DRAIN: begin
                busy        = 1'b1;
                w_nextState = PAIR;
            end
            PAIR: begin
                busy = 1'b1;
                if (w_lastPair) w_nextState = WRITE;
            end
            WRITE: begin
                busy        = 1'b1;
                mem_addr    = AW'(RESULT_ADDR);
                mem_wr_en   = 1'b1;
                mem_wr_data = DW'(r_min);
                w_nextState = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) w_nextState = LOAD;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Counters and running minimum; a fresh start always reinitialises the min.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k   <= '0;
            r_i   <= IW'(1);
            r_j   <= '0;
            r_min <= DIST_INIT;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_k   <= '0;
                        r_min <= DIST_INIT;
                    end
                end
                LOAD: r_k <= r_k + IW'(1);
                LOAD_DRAIN: begin
                    r_i <= IW'(1);
                    r_j <= '0;
                end
                PAIR: begin
                    if (w_dist < r_min) r_min <= w_dist;
                    if (r_j == r_i - IW'(1)) begin
                        r_i <= r_i + IW'(1);
                        r_j <= '0;
                    end else begin
                        r_j <= r_j + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data lags the address by one cycle, so LOAD cycle k stores sample k-1.
    always_ff @(posedge clk) begin
        if (r_state == LOAD && r_k != '0) begin
            r_buf[r_k - IW'(1)] <= sample_t'(mem_rd_data[7:0]);
        end else if (r_state == LOAD_DRAIN) begin
            r_buf[IW'(N - 1)] <= sample_t'(mem_rd_data[7:0]);
        end
    end

endmodule

// File: tb/tb_min_dist_engine.sv
// Directed bench for min_dist_engine: a 20-sample instance and a 2-sample
// instance, each with its own behavioural data memory and write monitor.
module tb_min_dist_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       start2;

    logic [7:0] memAddr;
    logic [7:0] memRdData;
    logic       memWrEn;
    logic [7:0] memWrData;
    logic       busy;
    logic       done;
    logic [7:0] minDist;

    logic [7:0] mem2Addr;
    logic [7:0] mem2RdData;
    logic       mem2WrEn;
    logic [7:0] mem2WrData;
    logic       busy2;
    logic       done2;
    logic [7:0] minDist2;

    logic [7:0] mem  [256];
    logic [7:0] mem2 [256];

    int         wrCount  = 0;
    logic [7:0] wrAddr   = 8'h00;
    logic [7:0] wrData   = 8'h00;
    int         wr2Count = 0;
    logic [7:0] wr2Addr  = 8'h00;
    logic [7:0] wr2Data  = 8'h00;

    int testsRun    = 0;
    int testsFailed = 0;
    int seed        = 1776;

    min_dist_engine #(.N(20), .BASE(128), .RESULT_ADDR(127), .AW(8), .DW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mem_addr    (memAddr),
        .mem_rd_data (memRdData),
        .mem_wr_en   (memWrEn),
        .mem_wr_data (memWrData),
        .busy        (busy),
        .done        (done),
        .min_dist    (minDist)
    );

    min_dist_engine #(.N(2), .BASE(128), .RESULT_ADDR(127), .AW(8), .DW(8)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .start       (start2),
        .mem_addr    (mem2Addr),
        .mem_rd_data (mem2RdData),
        .mem_wr_en   (mem2WrEn),
        .mem_wr_data (mem2WrData),
        .busy        (busy2),
        .done        (done2),
        .min_dist    (minDist2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memories; DUT writes are captured by monitors instead.
    always @(posedge clk) begin
        memRdData  <= mem[memAddr];
        mem2RdData <= mem2[mem2Addr];
        if (memWrEn) begin
            wrCount <= wrCount + 1;
            wrAddr  <= memAddr;
            wrData  <= memWrData;
        end
        if (mem2WrEn) begin
            wr2Count <= wr2Count + 1;
            wr2Addr  <= mem2Addr;
            wr2Data  <= mem2WrData;
        end
    end

    task automatic loadRamp();
        for (int k = 0; k < 20; k++) mem[128 + k] = 8'(k * 13 - 128);
    endtask

    function automatic int modelMin(input int n);
        int best = 255;
        for (int i = 1; i < n; i++) begin
            for (int j = 0; j < i; j++) begin
                int a = int'($signed(mem[128 + i]));
                int b = int'($signed(mem[128 + j]));
                int d = (a > b) ? a - b : b - a;
                if (d < best) best = d;
            end
        end
        return best;
    endfunction

    // Edges are counted including the start-sampling edge; -1 means timeout.
    task automatic runEngine(output int cycles, output int busyLow);
        cycles  = 0;
        busyLow = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1 start = 1'b0;
        while (cycles < 1000) begin
            @(posedge clk);
            cycles++;
            #1;
            if (done) break;
            if (!busy) busyLow++;
        end
        if (!done) cycles = -1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done got %b want 0", done); end
        testsRun++; if (memWrEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wr_en got %b want 0", memWrEn); end
        testsRun++; if (memAddr !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_addr got %h want 00", memAddr); end
        testsRun++; if (memWrData !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_wr_data got %h want 00", memWrData); end
        testsRun++; if (minDist !== 8'hFF) begin testsFailed++; $display("[TB] FAIL reset_min_dist got %h want ff", minDist); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ramp();
        int cycles, busyLow, wrBefore;
        loadRamp();
        wrBefore = wrCount;
        runEngine(cycles, busyLow);
        testsRun++; if (cycles !== 213) begin testsFailed++; $display("[TB] FAIL ramp_latency got %0d want 213", cycles); end
        testsRun++; if (busyLow !== 0) begin testsFailed++; $display("[TB] FAIL ramp_busy_gap got %0d want 0", busyLow); end
        testsRun++; if (wrCount - wrBefore !== 1) begin testsFailed++; $display("[TB] FAIL ramp_write_count got %0d want 1", wrCount - wrBefore); end
        testsRun++; if (wrAddr !== 8'd127) begin testsFailed++; $display("[TB] FAIL ramp_write_addr got %0d want 127", wrAddr); end
        testsRun++; if (wrData !== 8'd13) begin testsFailed++; $display("[TB] FAIL ramp_result got %0d want 13", wrData); end
        testsRun++; if (minDist !== 8'd13) begin testsFailed++; $display("[TB] FAIL ramp_min_dist got %0d want 13", minDist); end
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL ramp_done_busy got %b want 0", busy); end
        repeat (3) @(negedge clk);
        testsRun++; if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL ramp_done_hold got %b want 1", done); end
        testsRun++; if (memWrEn !== 1'b0) begin testsFailed++; $display("[TB] FAIL ramp_wr_en_idle got %b want 0", memWrEn); end
    endtask

    task automatic test_extremes();
        int cycles = 0;
        int wrBefore = wr2Count;
        mem2[128] = 8'h80;
        mem2[129] = 8'h7F;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1 start2 = 1'b0;
        while (cycles < 100 && !done2) begin
            @(posedge clk);
            cycles++;
            #1;
        end
        testsRun++; if (cycles !== 6) begin testsFailed++; $display("[TB] FAIL n2_latency got %0d want 6", cycles); end
        testsRun++; if (wr2Count - wrBefore !== 1) begin testsFailed++; $display("[TB] FAIL n2_write_count got %0d want 1", wr2Count - wrBefore); end
        testsRun++; if (wr2Addr !== 8'd127) begin testsFailed++; $display("[TB] FAIL n2_write_addr got %0d want 127", wr2Addr); end
        testsRun++; if (wr2Data !== 8'd255) begin testsFailed++; $display("[TB] FAIL n2_result got %0d want 255", wr2Data); end
        testsRun++; if (minDist2 !== 8'd255) begin testsFailed++; $display("[TB] FAIL n2_min_dist got %0d want 255", minDist2); end
    endtask

    task automatic test_duplicates();
        int cycles, busyLow;
        loadRamp();
        mem[140] = mem[133];
        runEngine(cycles, busyLow);
        testsRun++; if (cycles !== 213) begin testsFailed++; $display("[TB] FAIL dup_latency got %0d want 213", cycles); end
        testsRun++; if (wrData !== 8'd0) begin testsFailed++; $display("[TB] FAIL dup_result got %0d want 0", wrData); end
        testsRun++; if (minDist !== 8'd0) begin testsFailed++; $display("[TB] FAIL dup_min_dist got %0d want 0", minDist); end
    endtask

    // PAIR starts at edge count 22, so count 72 is fifty cycles into it.
    task automatic test_start_while_busy();
        int cycles = 0;
        int wrBefore;
        loadRamp();
        wrBefore = wrCount;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1 start = 1'b0;
        while (cycles < 1000) begin
            @(posedge clk);
            cycles++;
            #1;
            start = (cycles == 72);
            if (done) break;
        end
        start = 1'b0;
        testsRun++; if (cycles !== 213) begin testsFailed++; $display("[TB] FAIL busy_start_latency got %0d want 213", cycles); end
        testsRun++; if (wrCount - wrBefore !== 1) begin testsFailed++; $display("[TB] FAIL busy_start_writes got %0d want 1", wrCount - wrBefore); end
        testsRun++; if (wrData !== 8'd13) begin testsFailed++; $display("[TB] FAIL busy_start_result got %0d want 13", wrData); end
    endtask

    task automatic test_reset_mid_run();
        int cycles = 0;
        int busyLow, wrBefore;
        loadRamp();
        wrBefore = wrCount;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        #1 start = 1'b0;
        while (cycles < 100) begin
            @(posedge clk);
            cycles++;
        end
        #1 reset = 1'b1;
        #1;
        testsRun++; if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        testsRun++; if (minDist !== 8'hFF) begin testsFailed++; $display("[TB] FAIL midrst_min_dist got %h want ff", minDist); end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        testsRun++; if (wrCount !== wrBefore) begin testsFailed++; $display("[TB] FAIL midrst_no_write got %0d want %0d", wrCount, wrBefore); end
        runEngine(cycles, busyLow);
        testsRun++; if (cycles !== 213) begin testsFailed++; $display("[TB] FAIL midrst_latency got %0d want 213", cycles); end
        testsRun++; if (wrCount - wrBefore !== 1) begin testsFailed++; $display("[TB] FAIL midrst_writes got %0d want 1", wrCount - wrBefore); end
        testsRun++; if (wrData !== 8'd13) begin testsFailed++; $display("[TB] FAIL midrst_result got %0d want 13", wrData); end
    endtask

    task automatic test_random();
        int cycles, busyLow, expected;
        for (int k = 0; k < 20; k++) mem[128 + k] = 8'($random(seed));
        expected = modelMin(20);
        runEngine(cycles, busyLow);
        testsRun++; if (cycles !== 213) begin testsFailed++; $display("[TB] FAIL rand_latency got %0d want 213", cycles); end
        testsRun++; if (int'(wrData) !== expected) begin testsFailed++; $display("[TB] FAIL rand_result got %0d want %0d", wrData, expected); end
        testsRun++; if (int'(minDist) !== expected) begin testsFailed++; $display("[TB] FAIL rand_min_dist got %0d want %0d", minDist, expected); end
    endtask

    task automatic test_back_to_back();
        int cycles, busyLow, expected, wrBefore;
        testsRun++; if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_in_done got %b want 1", done); end
        for (int k = 0; k < 20; k++) mem[128 + k] = 8'($random(seed));
        expected = modelMin(20);
        wrBefore = wrCount;
        runEngine(cycles, busyLow);
        testsRun++; if (cycles !== 213) begin testsFailed++; $display("[TB] FAIL b2b_latency got %0d want 213", cycles); end
        testsRun++; if (wrCount - wrBefore !== 1) begin testsFailed++; $display("[TB] FAIL b2b_writes got %0d want 1", wrCount - wrBefore); end
        testsRun++; if (int'(wrData) !== expected) begin testsFailed++; $display("[TB] FAIL b2b_result got %0d want %0d", wrData, expected); end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        start2 = 1'b0;
        test_reset();
        test_ramp();
        test_extremes();
        test_duplicates();
        test_start_while_busy();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
